mem_requester: RTL and testbench

- Initiator side of the 16-bit word memory port: accepts load/store requests from the datapath or a loader over a valid/ready handshake and drives the memory's Address/DataIn/MemWrite.
- Captures the memory's registered read data, which is valid one clock after the address is presented, and returns it as a single-cycle response.
- Buffers up to 2 requests and rejects addresses beyond memory depth without touching memory.

---
 rtl/mem_requester_if.sv | 25 ++
 rtl/mem_requester.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_requester.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_requester_if.sv
// Request/response bundle between a datapath or loader and mem_requester.
// Latency: none, wires only.
// Backpressure: req_ready throttles requests; the response side cannot stall.
interface mem_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  // Request source / response sink (datapath, loader, testbench)
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // The requester itself
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_requester.sv
// Initiator for the 16-bit word memory port: buffers load/store requests, drives Address/DataIn/MemWrite, returns in-order responses.
// Latency from accept edge: store/error response 2 edges, load response 3 edges; 1 store/cycle, 1 load per 2 cycles back-to-back.
// Backpressure: req_ready falls when the request FIFO is full (and during reset); responses are single-cycle pulses with no stall.
// Optional MEM_REQ_STATS_EN adds saturating rd_count/wr_count/err_count outputs.

// Small generic synchronous FIFO; no bypass, pushes are ignored when full.
module mem_req_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] store_q [DEPTH];
  logic [WIDTH-1:0] store_d [DEPTH];

  // Extra pointer bit distinguishes full from empty when indices match
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = store_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage contents for push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    store_d  = store_q;
    if (push_vld && !full) begin
      store_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_rdy && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers, cleared by synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset; pointers define what is valid
  always_ff @(posedge clock) begin
    store_q <= store_d;
  end
endmodule

module mem_requester #(
  parameter int DEPTH      = 512,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  mem_requester_if.slave rq,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  input  logic [15:0] mem_rdata,
  output logic        busy
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);
  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_ERR     = 2'd3;

  // One extra bit so DEPTH up to 65536 compares correctly
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  logic [1:0]  state_q, state_d;
  req_t        issue_q, issue_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;

  logic        req_ready;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  req_t        fifo_head;
  req_t        req_in;
  logic        mem_active;

  // Nothing is accepted while reset is high, even though the FIFO is empty
  assign req_ready    = !fifo_full && !reset;
  assign fifo_push    = rq.req_valid && req_ready;
  assign req_in.write = rq.req_write;
  assign req_in.addr  = rq.req_addr;
  assign req_in.wdata = rq.req_wdata;

  mem_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (fifo_push),
    .push_dat (req_in),
    .pop_rdy  (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sequencer: each completing state either pops the next request or returns to IDLE
  always_comb begin
    logic advance;
    state_d     = state_q;
    issue_d     = issue_q;
    fifo_pop    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 16'h0000;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        advance = 1'b1;
      end
      ST_ISSUE: begin
        if (issue_q.write) begin
          // Memory takes the write on this same edge, so the ack goes out now
          rsp_valid_d = 1'b1;
          advance     = 1'b1;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Memory read data registered on the ISSUE closing edge is valid now
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_rdata;
        advance     = 1'b1;
      end
      default: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        advance     = 1'b1;
      end
    endcase

    if (advance) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        issue_d  = fifo_head;
        state_d  = ({1'b0, fifo_head.addr} < DEPTH_LIM) ? ST_ISSUE : ST_ERR;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // FSM, issue register and response registers; reset drops anything in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      issue_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Memory port is driven only in ISSUE/CAPTURE and forced idle during reset so
  // the memory's reset-time image load is never disturbed
  assign mem_active = !reset && ((state_q == ST_ISSUE) || (state_q == ST_CAPTURE));
  assign mem_addr   = mem_active ? issue_q.addr : 16'h0000;
  assign mem_wdata  = (mem_active && issue_q.write) ? issue_q.wdata : 16'h0000;
  assign mem_write  = !reset && (state_q == ST_ISSUE) && issue_q.write;

  // Response outputs are masked during reset so a stale pulse never escapes
  assign rq.req_ready = req_ready;
  assign rq.rsp_valid = rsp_valid_q && !reset;
  assign rq.rsp_err   = rsp_err_q && !reset;
  assign rq.rsp_rdata = reset ? 16'h0000 : rsp_rdata_q;
  assign busy         = !reset && (!fifo_empty || (state_q != ST_IDLE));

`ifdef MEM_REQ_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] err_count_q, err_count_d;

  // Saturating per-kind counters, bumped on the edge the response is produced
  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    if ((state_q == ST_CAPTURE) && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if ((state_q == ST_ISSUE) && issue_q.write && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    if ((state_q == ST_ERR) && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count_q  <= 16'h0000;
      wr_count_q  <= 16'h0000;
      err_count_q <= 16'h0000;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester with a registered-read memory model.
// Latency: checks response latency for isolated requests started from idle.
// Backpressure: holds req_valid until req_ready and records stalls.
module tb_mem_requester;
  logic        clock;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [15:0] mem_rdata;
  logic        busy;
`ifdef MEM_REQ_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic [15:0] err_count;
`endif

  mem_requester_if rq ();

  mem_requester #(
    .DEPTH      (512),
    .FIFO_DEPTH (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rq        (rq),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef MEM_REQ_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          kind;   // 0 load, 1 store, 2 error
    int          lat;    // 0 = not checked
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [512];
  logic [15:0] mem [512];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          rsp_seen = 0;
  int          wr_seen = 0;
  int          tally_rd = 0;
  int          tally_wr = 0;
  int          tally_er = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] img(input int i);
    return 16'((i * 257) ^ 32'h3C5A);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: registered read, write on edge, image reloaded while in reset
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= img(i);
      mem_rdata <= 16'h0000;
    end else begin
      if (mem_write) mem[mem_addr[8:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[8:0]];
    end
  end

  // Response monitor and scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (mem_write) begin
      wr_seen++;
      check_eq("write_in_range", {31'b0, mem_addr < 16'd512}, 1);
    end
    if (rq.rsp_valid) begin
      rsp_seen++;
      check_eq("rsp_expected", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("rsp_err", rq.rsp_err, e.err);
        check_eq("rsp_rdata", rq.rsp_rdata, e.rdata);
        if (e.lat > 0) check_eq("rsp_latency", cyc - e.acc, e.lat);
        if (e.kind == 0) tally_rd++;
        else if (e.kind == 1) tally_wr++;
        else tally_er++;
      end
    end
  end

  task automatic do_reset(input int n, input logic hold_valid);
    reset = 1'b1;
    rq.req_valid = hold_valid;
    exp_q.delete();
    for (int i = 0; i < 512; i++) ref_mem[i] = img(i);
    tally_rd = 0;
    tally_wr = 0;
    tally_er = 0;
    repeat (n) begin
      @(negedge clock);
      check_eq("rst_mem_write", mem_write, 0);
      check_eq("rst_req_ready", rq.req_ready, 0);
      check_eq("rst_rsp_valid", rq.rsp_valid, 0);
      check_eq("rst_busy", busy, 0);
    end
    reset = 1'b0;
    rq.req_valid = 1'b0;
  endtask

  // Offer one request (valid left high), wait for accept, record expectation
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d, input int lat);
    int   t;
    exp_t e;
    t = 0;
    rq.req_valid = 1'b1;
    rq.req_write = w;
    rq.req_addr  = a;
    rq.req_wdata = d;
    while (!rq.req_ready && t < 50) begin
      @(negedge clock);
      t++;
      stalls++;
    end
    if (t >= 50) check_eq("accept_timeout", t, 0);
    @(posedge clock);
    @(negedge clock);
    e.acc = cyc;
    e.lat = lat;
    if (a >= 16'd512) begin
      e.err = 1'b1; e.rdata = 16'h0000; e.kind = 2;
    end else if (w) begin
      e.err = 1'b0; e.rdata = 16'h0000; e.kind = 1;
      ref_mem[a[8:0]] = d;
    end else begin
      e.err = 1'b0; e.rdata = ref_mem[a[8:0]]; e.kind = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rq.req_valid = 1'b0;
    while ((busy || rq.rsp_valid || exp_q.size() != 0) && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) check_eq("drain_timeout", t, 0);
    @(negedge clock);
  endtask

  initial begin
    int s0;
    int w0;
    int r0;
    reset        = 1'b1;
    rq.req_valid = 1'b0;
    rq.req_write = 1'b0;
    rq.req_addr  = 16'h0000;
    rq.req_wdata = 16'h0000;
    @(negedge clock);

    // Reset held 3 cycles with req_valid high
    do_reset(3, 1'b1);
    repeat (4) @(negedge clock);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_rsp_cnt", rsp_seen, 0);
    check_eq("post_rst_ready", rq.req_ready, 1);

    // Store then load to the same address, isolated, with latency checks
    send(1'b1, 16'd5, 16'h1234, 2);
    drain();
    send(1'b0, 16'd5, 16'h0000, 3);
    drain();
    check_eq("idle_mem_addr", mem_addr, 0);
    check_eq("idle_mem_write", mem_write, 0);

    // Four back-to-back requests with valid held
    r0 = rsp_seen;
    send(1'b1, 16'd10, 16'hAAAA, 0);
    send(1'b1, 16'd11, 16'h5555, 0);
    send(1'b0, 16'd10, 16'h0000, 0);
    send(1'b0, 16'd11, 16'h0000, 0);
    drain();
    check_eq("b2b_pulses", rsp_seen - r0, 4);

    // Back-to-back loads fill the 2-entry buffer and drop req_ready
    s0 = stalls;
    r0 = rsp_seen;
    send(1'b0, 16'd11, 16'h0000, 0);
    send(1'b0, 16'd10, 16'h0000, 0);
    send(1'b0, 16'd11, 16'h0000, 0);
    send(1'b0, 16'd10, 16'h0000, 0);
    drain();
    check_eq("ready_drop", {31'b0, stalls > s0}, 1);
    check_eq("load_burst_pulses", rsp_seen - r0, 4);

    // Address boundary: 511 valid, 512 and 16'hFFFF are errors, no memory write
    send(1'b0, 16'd511, 16'h0000, 3);
    drain();
    w0 = wr_seen;
    send(1'b0, 16'd512, 16'h0000, 2);
    drain();
    send(1'b1, 16'hFFFF, 16'hBEEF, 2);
    drain();
    check_eq("err_no_write", wr_seen - w0, 0);

    // Out-of-range store must not alias onto addr 88
    w0 = wr_seen;
    send(1'b1, 16'd600, 16'hFFFF, 2);
    drain();
    check_eq("alias_no_write", wr_seen - w0, 0);
    send(1'b0, 16'd88, 16'h0000, 3);
    drain();

`ifdef MEM_REQ_STATS_EN
    check_eq("rd_count", rd_count, tally_rd);
    check_eq("wr_count", wr_count, tally_wr);
    check_eq("err_count", err_count, tally_er);
`endif

    // Reset during CAPTURE of a load with one more load buffered
    r0 = rsp_seen;
    send(1'b0, 16'd20, 16'h0000, 0);
    send(1'b0, 16'd21, 16'h0000, 0);
    rq.req_valid = 1'b0;
    @(negedge clock);
    check_eq("mid_busy", busy, 1);
    do_reset(2, 1'b0);
    repeat (6) @(negedge clock);
    check_eq("mid_no_rsp", rsp_seen - r0, 0);
    check_eq("mid_busy_after", busy, 0);
`ifdef MEM_REQ_STATS_EN
    check_eq("rd_count_rst", rd_count, 0);
    check_eq("wr_count_rst", wr_count, 0);
    check_eq("err_count_rst", err_count, 0);
`endif
    send(1'b0, 16'd5, 16'h0000, 3);
    drain();
    check_eq("final_rsp_delta", rsp_seen - r0, 1);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
